mioc_gate_test_seq: RTL
=======================

Name: mioc_gate_test_seq

Overview:
On-chip pattern sequencer for MIOC gate-under-test characterisation, e.g. the NMOS NOR2 cell.
- Holds a small loadable pattern table and drives the gate inputs in1/in2 from it.
- After each pattern, waits a programmable settle time, then samples the gate output z and compares it with the stored expected value.
- Reports error count, first failing index and completion, so the bench or scan logic only loads, starts and reads back.

Parameters:
DEPTH, 16, number of pattern table entries.
AW, 4, pattern address width; DEPTH = 2**AW.
SETTLE, 4, cycles in-stimulus is held before z is sampled; legal range 1..255.

Ports:
clk  input  1  single clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
wr_en  input  1  pattern table write strobe; ignored while busy.
wr_addr  input  AW  table write address.
wr_data  input  3  pattern entry: bit2 = expected z, bit1 = in1, bit0 = in2.
num_pat  input  AW+1  patterns to run; values above DEPTH clamp to DEPTH; 0 = empty run.
start  input  1  run request, sampled only in IDLE.
in1  output  1  gate input 1 (to DUT).
in2  output  1  gate input 2 (to DUT).
z  input  1  gate output (from DUT).
busy  output  1  high from the cycle after start is accepted until DONE is left.
done  output  1  sticky run-complete flag; cleared by next accepted start or reset.
err_cnt  output  AW+1  mismatch count, saturating at all-ones.
fail  output  1  sticky: at least one mismatch this run.
first_fail_idx  output  AW  index of the first mismatching pattern; valid when fail = 1.
sample_valid  output  1  one-cycle pulse when z is captured.
sample_z  output  1  captured z value, updated with sample_valid.

Behaviour:
- Reset (async assert, sync release): state = IDLE, and all outputs are 0, including in1, in2, busy, done, err_cnt, fail, first_fail_idx, sample_valid and sample_z. The pattern table is not reset.
- Table writes occur on a clock edge with wr_en = 1 and state IDLE. Writes in any other state are dropped.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE:
  - With start = 1 and clamped num_pat > 0, latch the clamped count and clear idx, err_cnt, fail, first_fail_idx and done. Go to APPLY.
  - With start = 1 and num_pat = 0, clear the same registers and go to DONE.
- APPLY: in1/in2 <= table[idx][1:0]; load settle counter with SETTLE; go to SETTLE.
- SETTLE: decrement the counter; on reaching 0, go to SAMPLE. in1/in2 hold.
- SAMPLE:
  - Register z into sample_z and pulse sample_valid.
  - If z != table[idx][2]: increment err_cnt (saturating). If fail was 0, set first_fail_idx = idx and fail = 1.
  - If idx = count-1, go to DONE; else idx++ and go to APPLY.
- DONE: set done = 1; go to IDLE. in1/in2 keep their last values until the next APPLY.
- busy is high in APPLY, SETTLE, SAMPLE and DONE.
- Timing: each pattern takes SETTLE+2 cycles. done rises num_pat*(SETTLE+2)+1 cycles after the edge that accepts start. An empty run completes in 1 cycle.
- start while busy is ignored and not queued.
- Reset mid-run aborts immediately to reset values. No partial results are retained.
- z is treated as combinational from in1/in2. SETTLE must cover DUT delay; no synchroniser is included.

Optional Feature:
MIOC_SEQ_STOP_ON_FAIL_EN.
- Defined: on the first mismatch, SAMPLE goes directly to DONE regardless of idx. err_cnt ends at 1, and first_fail_idx marks the stop point.
- Undefined: all count patterns always run, and err_cnt totals every mismatch.

Test Plan:
- Load the NOR truth table as 0x4, 0x1, 0x2, 0x3 (expected/in1/in2). Model a good NOR2. Set num_pat = 4, SETTLE = 4, pulse start. Required: done at cycle 25, err_cnt = 0, fail = 0, and 4 sample_valid pulses with sample_z = 1, 0, 0, 0.
- Same table, DUT z stuck at 0. Required: err_cnt = 1, fail = 1, first_fail_idx = 0. With MIOC_SEQ_STOP_ON_FAIL_EN, done arrives at cycle 7 with only 1 sample_valid.
- num_pat = 0, start. Required: done = 1 one cycle later, busy high for exactly 1 cycle, err_cnt = 0, in1/in2 unchanged.
- num_pat = 20 with DEPTH = 16. Required: exactly 16 samples, and done at cycle 16*6+1 = 97.
- Pulse start and write table[0] = 0x7 during the run. Required: both ignored; the run and table contents are unaffected.
- Assert rst during SETTLE of pattern 2. Required: in1, in2, busy, done and err_cnt are all 0 immediately. A following start reruns from idx 0 with the table intact.

Source files
------------

// File: rtl/mioc_gate_test_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mioc_gate_test_seq
//  Purpose  : Pattern sequencer that drives a gate-under-test (in1/in2),
//             waits a settle time, samples z and scores it against the table.
//  Option   : MIOC_SEQ_STOP_ON_FAIL_EN - end the run at the first mismatch.
//  Revision : 1.0 - initial release
// ============================================================================
module mioc_gate_test_seq #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int SETTLE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [2:0]    wr_data,
    input  logic [AW:0]   num_pat,
    input  logic          start,
    output logic          in1,
    output logic          in2,
    input  logic          z,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   err_cnt,
    output logic          fail,
    output logic [AW-1:0] first_fail_idx,
    output logic          sample_valid,
    output logic          sample_z
);

    localparam logic [2:0] c_s_idle   = 3'd0;
    localparam logic [2:0] c_s_apply  = 3'd1;
    localparam logic [2:0] c_s_settle = 3'd2;
    localparam logic [2:0] c_s_sample = 3'd3;
    localparam logic [2:0] c_s_done   = 3'd4;

    localparam logic [AW:0]   c_depth   = DEPTH[AW:0];
    localparam logic [AW:0]   c_cnt_one = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] c_idx_one = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [7:0]    c_settle  = SETTLE[7:0];

    logic [2:0]    r_table [DEPTH];
    logic [2:0]    r_state;
    logic [AW-1:0] r_idx;
    logic [AW:0]   r_count;
    logic [7:0]    r_settle_cnt;

    logic [AW:0]   w_clamped;
    logic          w_mismatch;
    logic          w_last;
    logic          w_stop;

    assign w_clamped  = (num_pat > c_depth) ? c_depth : num_pat;
    assign w_mismatch = (z != r_table[r_idx][2]);
    assign w_last     = ({1'b0, r_idx} == (r_count - c_cnt_one));
`ifdef MIOC_SEQ_STOP_ON_FAIL_EN
    assign w_stop     = w_last | w_mismatch;
`else
    assign w_stop     = w_last;
`endif
    assign busy       = (r_state != c_s_idle);

    // The table is deliberately not reset so it survives an aborted run.
    always_ff @(posedge clk) begin
        if (wr_en && (r_state == c_s_idle)) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_s_idle;
            r_idx          <= '0;
            r_count        <= '0;
            r_settle_cnt   <= '0;
            in1            <= 1'b0;
            in2            <= 1'b0;
            done           <= 1'b0;
            err_cnt        <= '0;
            fail           <= 1'b0;
            first_fail_idx <= '0;
            sample_valid   <= 1'b0;
            sample_z       <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (r_state)
                c_s_idle: begin
                    if (start) begin
                        r_idx          <= '0;
                        err_cnt        <= '0;
                        fail           <= 1'b0;
                        first_fail_idx <= '0;
                        done           <= 1'b0;
                        r_count        <= w_clamped;
                        r_state        <= (w_clamped != '0) ? c_s_apply : c_s_done;
                    end
                end
                c_s_apply: begin
                    in1          <= r_table[r_idx][1];
                    in2          <= r_table[r_idx][0];
                    r_settle_cnt <= c_settle;
                    r_state      <= c_s_settle;
                end
                c_s_settle: begin
                    // SETTLE >= 1, so the counter is never entered at zero.
                    r_settle_cnt <= r_settle_cnt - 8'd1;
                    if (r_settle_cnt == 8'd1) begin
                        r_state <= c_s_sample;
                    end
                end
                c_s_sample: begin
                    sample_z     <= z;
                    sample_valid <= 1'b1;
                    if (w_mismatch) begin
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + c_cnt_one;
                        end
                        if (!fail) begin
                            fail           <= 1'b1;
                            first_fail_idx <= r_idx;
                        end
                    end
                    if (w_stop) begin
                        r_state <= c_s_done;
                    end else begin
                        r_idx   <= r_idx + c_idx_one;
                        r_state <= c_s_apply;
                    end
                end
                c_s_done: begin
                    done    <= 1'b1;
                    r_state <= c_s_idle;
                end
                default: begin
                    r_state <= c_s_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
